// File: rtl/stream_demux_nch.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshakes.
// Each output channel owns a one-entry holding register; routing is by select or round-robin.
module stream_demux_nch #(
    parameter int WIDTH = 4,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    output logic [N_OUT*WIDTH-1:0]   out_data,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [SEL_W-1:0]         rr_ptr
);

    logic [SEL_W-1:0] target;
    logic             accept;

    // A full target can still take a word when its consumer drains in the same cycle.
    assign target   = mode ? rr_ptr : sel;
    assign in_ready = !out_valid[target] || out_ready[target];
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (accept && (target == SEL_W'(i))) begin
                    out_data[i*WIDTH +: WIDTH] <= in_data;
                    out_valid[i]               <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            // N_OUT is a power of two, so the natural wrap of SEL_W bits is modulo N_OUT.
            if (accept && mode) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_nch.sv
// Self-checking bench for stream_demux_nch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural channel model.
module tb_stream_demux_nch;

    localparam int WIDTH = 4;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       sel;
    logic                   mode;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [SEL_W-1:0]       rr_ptr;

    int errors = 0;
    int checks = 0;

    // Model: per channel, whether an undelivered word is held and the last word loaded.
    bit               m_full [N_OUT];
    logic [WIDTH-1:0] m_last [N_OUT];
    int               m_rr;
    bit               model_known = 1'b0;
    int               delivered = 0;
    int               accepted  = 0;

    always #5 clk = ~clk;

    stream_demux_nch #(.WIDTH(WIDTH), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, compare the DUT against the model, then advance the model
    // to what the coming rising edge must produce.
    task automatic applyStimulus(input logic r, input logic m, input logic [SEL_W-1:0] s,
                                 input logic [WIDTH-1:0] d, input logic v,
                                 input logic [N_OUT-1:0] rdy);
        logic [N_OUT-1:0]       exp_valid;
        logic [N_OUT*WIDTH-1:0] exp_data;
        int                     t;
        bit                     exp_ready;
        bit                     take;

        @(negedge clk);
        rst       = r;
        mode      = m;
        sel       = s;
        in_data   = d;
        in_valid  = v;
        out_ready = rdy;
        #1;

        t = m ? m_rr : int'(s);
        exp_ready = !m_full[t] || rdy[t];
        for (int i = 0; i < N_OUT; i++) begin
            exp_valid[i]               = m_full[i];
            exp_data[i*WIDTH +: WIDTH] = m_last[i];
        end

        if (model_known) begin
            checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
            checkOutput("out_data",  64'(out_data),  64'(exp_data));
            checkOutput("rr_ptr",    64'(rr_ptr),    64'(m_rr));
            checkOutput("in_ready",  64'(in_ready),  64'(exp_ready));
        end

        if (r) begin
            for (int i = 0; i < N_OUT; i++) begin
                m_full[i] = 1'b0;
                m_last[i] = '0;
            end
            m_rr        = 0;
            model_known = 1'b1;
        end else begin
            take = v && exp_ready;
            for (int i = 0; i < N_OUT; i++) begin
                if (m_full[i] && rdy[i]) begin
                    m_full[i] = 1'b0;
                    delivered++;
                end
            end
            if (take) begin
                m_full[t] = 1'b1;
                m_last[t] = d;
                accepted++;
                if (m) m_rr = (m_rr + 1) % N_OUT;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        m_rr      = 0;
        for (int i = 0; i < N_OUT; i++) begin
            m_full[i] = 1'b0;
            m_last[i] = '0;
        end

        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);

        // Reset state, then a single select-mode word into channel 2.
        applyStimulus(1'b0, 1'b0, 2'd2, 4'hA, 1'b1, 4'b0000);
        checkOutput("reset_valid", 64'(out_valid), 64'h0);
        checkOutput("reset_data",  64'(out_data),  64'h0);
        checkOutput("reset_rr",    64'(rr_ptr),    64'h0);
        checkOutput("reset_ready", 64'(in_ready),  64'h1);
        applyStimulus(1'b0, 1'b0, 2'd2, 4'h3, 1'b1, 4'b0000);
        checkOutput("sel2_valid", 64'(out_valid), 64'h4);
        checkOutput("sel2_data",  64'(out_data),  64'h0A00);
        checkOutput("stall_ready", 64'(in_ready), 64'h0);

        // Backpressure released: delivery of A and load of 5 on the same edge.
        applyStimulus(1'b0, 1'b0, 2'd2, 4'h5, 1'b1, 4'b0100);
        checkOutput("stall_hold", 64'(out_data[8 +: 4]), 64'hA);
        checkOutput("swap_ready", 64'(in_ready), 64'h1);
        applyStimulus(1'b0, 1'b0, 2'd2, 4'h0, 1'b0, 4'b0000);
        checkOutput("swap_valid", 64'(out_valid[2]), 64'h1);
        checkOutput("swap_data",  64'(out_data[8 +: 4]), 64'h5);

        // Round-robin with everything draining; five words wrap back to channel 0.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 2'd3, 4'(k + 1), 1'b1, 4'b1111);
            checkOutput("rr_seq", 64'(rr_ptr), 64'(k % 4));
            if (k > 0) checkOutput("rr_onehot", 64'(out_valid), 64'(1 << ((k - 1) % 4)));
        end
        applyStimulus(1'b0, 1'b1, 2'd0, 4'h0, 1'b0, 4'b0000);
        checkOutput("rr_wrap_ptr",   64'(rr_ptr),    64'h1);
        checkOutput("rr_wrap_valid", 64'(out_valid), 64'h1);
        checkOutput("rr_wrap_data",  64'(out_data),  64'h4325);

        // Channel 1 drains while channel 3 loads on the same edge.
        applyStimulus(1'b0, 1'b0, 2'd1, 4'h9, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd3, 4'h7, 1'b1, 4'b0010);
        checkOutput("indep_pre", 64'(out_valid), 64'h3);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);
        checkOutput("indep_valid", 64'(out_valid), 64'h9);
        checkOutput("indep_slot3", 64'(out_data[12 +: 4]), 64'h7);

        // Mode switch keeps rr_ptr across a select-mode transfer.
        applyStimulus(1'b0, 1'b1, 2'd0, 4'h6, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h8, 1'b1, 4'b0001);
        checkOutput("msw_rr", 64'(rr_ptr), 64'h2);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'hB, 1'b1, 4'b0000);
        checkOutput("msw_rr_hold", 64'(rr_ptr), 64'h2);
        checkOutput("msw_slot0",   64'(out_data[0 +: 4]), 64'h8);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'h0, 1'b0, 4'b0000);
        checkOutput("msw_slot2", 64'(out_data[8 +: 4]), 64'hB);
        checkOutput("msw_rr_next", 64'(rr_ptr), 64'h3);

        // Reset while every channel is full.
        applyStimulus(1'b1, 1'b0, 2'd1, 4'hF, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b1, 2'd1, 4'h0, 1'b0, 4'b0000);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'h0);
        checkOutput("mid_rst_data",  64'(out_data),  64'h0);
        checkOutput("mid_rst_rr",    64'(rr_ptr),    64'h0);
        checkOutput("mid_rst_ready", 64'(in_ready),  64'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(1'($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 1)),
                          SEL_W'($urandom),
                          WIDTH'($urandom),
                          1'($urandom_range(0, 3) != 0),
                          N_OUT'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);

        $display("[TB] accepted=%0d delivered=%0d", accepted, delivered);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_nch.md
Name: stream_demux_nch

Overview:
- Parametrised, registered 1-to-N demultiplexer for multi-bit data words with valid/ready flow control.
- Generalises the fixed 1x4 4-bit gate-level demux:
  - width and channel count are parameters;
  - each output channel has a one-entry holding register;
  - two routing modes: explicit select and round-robin.
- Sits between a single producer and N consumers. Used to fan a data stream out to per-channel datapaths (display digits, FIFOs, etc.).

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- N_OUT, 4, number of output channels (power of 2, >=2).
- SEL_W, 2, select width; must equal log2(N_OUT).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input data word.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- sel  input  SEL_W  target channel in select mode.
- mode  input  1  0 = select mode (target = sel), 1 = round-robin mode (target = rr_ptr).
- out_data  output  N_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  N_OUT  channel i holds an undelivered word.
- out_ready  input  N_OUT  consumer i accepts its word this cycle.
- rr_ptr  output  SEL_W  current round-robin pointer.

Behaviour:
- Target channel t (combinational): t = mode ? rr_ptr : sel.
- in_ready = !out_valid[t] || out_ready[t] (combinational).
  - in_ready never depends on in_valid.
  - The out_ready-to-in_ready path is combinational by design.
- Accept: in_valid && in_ready at a rising edge. On accept:
  - slot t <= in_data;
  - out_valid[t] <= 1.
- Latency: word accepted at edge k appears on out_data slot t with out_valid[t]=1 after edge k (1 cycle).
- Drain: out_valid[i] && out_ready[i] with no load into channel i at the same edge -> out_valid[i] <= 0.
- Simultaneous drain and load on the same channel:
  - load wins, out_valid stays 1, new word replaces the old one;
  - the old word counts as delivered (it was handshaken).
- Channels other than t are unaffected by an accept and drain independently in the same cycle.
- out_data slot i changes only on a load into channel i.
  - Data is stable while out_valid[i] && !out_ready[i].
  - The slot keeps its last value after draining.
- out_ready[i] while out_valid[i]=0 is ignored.
- Round-robin pointer:
  - increments by 1 modulo N_OUT on each accept while mode=1 (N_OUT-1 wraps to 0);
  - holds in mode 0 and when no accept occurs.
- Mode and sel may change every cycle.
  - The new target applies immediately, including to in_ready in that cycle.
  - Switching modes does not reset rr_ptr.
- Stall: if channel t is full and its out_ready[t]=0, in_ready=0. The producer holds; no word is lost or duplicated.
- Ordering: words routed to the same channel are delivered in acceptance order.
- Reset (rst=1 at a rising edge, takes priority over everything, valid mid-transfer):
  - out_valid = 0 (all channels);
  - out_data = 0 (all slots);
  - rr_ptr = 0;
  - pending words are discarded.
  - After reset, in_ready = 1 for any target.
- No X propagation: in_data is captured only on accept.

Test Plan:
- Reset, then mode=0, sel=2, in_data=4'hA, in_valid for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100, slot2=4'hA, other slots 0, rr_ptr=0.
- Backpressure: channel 2 full, out_ready[2]=0, sel=2, in_valid=1 -> in_ready=0 and slot2 stays 4'hA. Then:
  - raise out_ready[2] with in_data=4'h5 -> same edge delivers 4'hA and loads 4'h5;
  - out_valid[2] stays 1.
- Round-robin: mode=1, all out_ready=1, in_data 1,2,3,4,5 on consecutive cycles ->
  - words land in channels 0,1,2,3,0;
  - rr_ptr sequence 0,1,2,3,0,1 (wrap checked).
- Independent drain: channel 1 full, channel 3 target with sel=3, out_ready=4'b0010, in_data=4'h7 -> same edge:
  - out_valid[1] clears;
  - out_valid[3] sets with slot3=4'h7.
- Mode switch: rr_ptr=2 in mode 1, switch to mode 0 with sel=0 and accept a word -> word goes to channel 0, rr_ptr stays 2; return to mode 1 -> next word goes to channel 2.
- Reset mid-operation: two channels full with out_ready=0, assert rst one cycle -> out_valid=0, all slots 0, rr_ptr=0, in_ready=1 on the following cycle.
